// File: rtl/dff_pkg.sv
// Shared defaults and sizing helper for the dff delay-line blocks.
package dff_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Bits needed to count 0..depth valid stages.
  function automatic int clog2_depth(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_res_en.sv
// One register with async active-high reset, synchronous clear and enable.
module dff_res_en #(
  parameter int           W       = 9,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         res,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear outranks enable so a flush also discards the word on that edge.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dff_pipe_res.sv
// DEPTH-stage data+valid delay line with stall, flush, reset value and occupancy count.
module dff_pipe_res
  import dff_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter int               DEPTH    = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter bit               GATE_INV = 1'b1,
  localparam int              CW       = clog2_depth(DEPTH)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  output logic [CW-1:0]    cnt
);

  // Valid semantics: q_vld qualifies q on every cycle; there is no ready, so a
  // consumer must take each word in the cycle after the enabled edge that moved it out.

  if (DEPTH < 1) begin : g_bad_depth
    $error("dff_pipe_res: DEPTH must be >= 1");
  end

  logic [WIDTH:0]   stg [DEPTH];
  logic [DEPTH-1:0] vld_vec;
  logic [WIDTH-1:0] d_gated;
  logic [CW-1:0]    cnt_r;

  // Invalid input words are replaced so garbage on d never travels down the line.
  assign d_gated = (GATE_INV && !d_vld) ? RST_VAL : d;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH:0] din;

    if (k == 0) begin : g_head
      assign din = {d_vld, d_gated};
    end else begin : g_body
      assign din = stg[k-1];
    end

    dff_res_en #(
      .W       (WIDTH + 1),
      .RST_VAL ({1'b0, RST_VAL})
    ) u_reg (
      .clk (clk),
      .res (res),
      .en  (en),
      .clr (flush),
      .d   (din),
      .q   (stg[k])
    );

    assign vld_vec[k] = stg[k][WIDTH];
  end

  assign q     = stg[DEPTH-1][WIDTH-1:0];
  assign q_vld = stg[DEPTH-1][WIDTH];

  // Modular add/sub stays exact: a full line always has q_vld=1, so the net change is bounded.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_r <= '0;
    end else if (flush) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + CW'(d_vld) - CW'(q_vld);
    end
  end

  assign cnt = cnt_r;

  a_cnt_popcount : assert property (@(posedge clk) disable iff (res)
    cnt_r == CW'($countones(vld_vec)));

  a_cnt_bound : assert property (@(posedge clk) disable iff (res)
    int'(cnt_r) <= DEPTH);

endmodule

// File: tb/tb_dff_pipe_res.sv
// Scoreboard bench for dff_pipe_res: DEPTH=4 gated, DEPTH=1 gated, DEPTH=4 ungated.
module tb_dff_pipe_res;

  localparam logic [7:0] RV = 8'hA5;

  // clock / reset / shared stimulus
  logic       clk;
  logic       res;
  logic       en;
  logic       flush;
  logic [7:0] d;
  logic       d_vld;

  logic [7:0] q4, q1, qg;
  logic       v4, v1, vg;
  logic [2:0] c4, cg;
  logic [0:0] c1;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp4[$];
  logic [7:0] exp1[$];
  logic [7:0] expg[$];

  logic [3:0] m4, mg;
  logic       m1;
  logic       adv;

  dff_pipe_res #(.WIDTH(8), .DEPTH(4), .RST_VAL(RV), .GATE_INV(1'b1)) u_d4 (
    .clk(clk), .res(res), .en(en), .flush(flush), .d(d), .d_vld(d_vld),
    .q(q4), .q_vld(v4), .cnt(c4)
  );

  dff_pipe_res #(.WIDTH(8), .DEPTH(1), .RST_VAL(RV), .GATE_INV(1'b1)) u_d1 (
    .clk(clk), .res(res), .en(en), .flush(flush), .d(d), .d_vld(d_vld),
    .q(q1), .q_vld(v1), .cnt(c1)
  );

  dff_pipe_res #(.WIDTH(8), .DEPTH(4), .RST_VAL(RV), .GATE_INV(1'b0)) u_g0 (
    .clk(clk), .res(res), .en(en), .flush(flush), .d(d), .d_vld(d_vld),
    .q(qg), .q_vld(vg), .cnt(cg)
  );

  initial begin
    clk = 1'b0;
    #5;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected valid occupancy per instance.
  always @(posedge clk or posedge res) begin
    if (res) begin
      m4 <= '0; m1 <= 1'b0; mg <= '0;
    end else if (flush) begin
      m4 <= '0; m1 <= 1'b0; mg <= '0;
    end else if (en) begin
      m4 <= {m4[2:0], d_vld};
      m1 <= d_vld;
      mg <= {mg[2:0], d_vld};
    end
  end

  always @(posedge clk) adv <= en && !flush && !res;

  // monitor: per-cycle occupancy checks and scoreboard pops on each new output word
  always @(negedge clk) begin
    check("cnt4", 32'(c4), 32'($countones(m4)));
    check("cnt1", 32'(c1), 32'(m1));
    check("cntg", 32'(cg), 32'($countones(mg)));
    check("vld4", 32'(v4), 32'(m4[3]));
    check("vld1", 32'(v1), 32'(m1));
    check("vldg", 32'(vg), 32'(mg[3]));
    if (adv && v4) begin
      if (exp4.size() == 0) check("sb4_underflow", 32'(exp4.size()), 32'd1);
      else check("sb4", 32'(q4), 32'(exp4.pop_front()));
    end
    if (adv && v1) begin
      if (exp1.size() == 0) check("sb1_underflow", 32'(exp1.size()), 32'd1);
      else check("sb1", 32'(q1), 32'(exp1.pop_front()));
    end
    if (adv && vg) begin
      if (expg.size() == 0) check("sbg_underflow", 32'(expg.size()), 32'd1);
      else check("sbg", 32'(qg), 32'(expg.pop_front()));
    end
  end

  task automatic clear_q();
    exp4.delete();
    exp1.delete();
    expg.delete();
  endtask

  // driver: apply one vector after a negedge, return just after the next posedge
  task automatic step(input logic e, input logic f, input logic v, input logic [7:0] dd);
    @(negedge clk);
    #1;
    en = e; flush = f; d_vld = v; d = dd;
    if (f) begin
      clear_q();
    end else if (e && v) begin
      exp4.push_back(dd);
      exp1.push_back(dd);
      expg.push_back(dd);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    res = 1'b0; en = 1'b0; flush = 1'b0; d = 8'h00; d_vld = 1'b0;
    #1 res = 1'b1;
    #1;
    check("rst_q4", 32'(q4), 32'(RV));
    check("rst_v4", 32'(v4), 32'd0);
    check("rst_c4", 32'(c4), 32'd0);
    check("rst_q1", 32'(q1), 32'(RV));
    check("rst_c1", 32'(c1), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b0;

    // latency
    step(1'b1, 1'b0, 1'b1, 8'h11);
    check("lat1_q1", 32'(q1), 32'h11);
    check("lat1_v4", 32'(v4), 32'd0);
    step(1'b1, 1'b0, 1'b1, 8'h22);
    step(1'b1, 1'b0, 1'b1, 8'h33);
    check("lat3_v4", 32'(v4), 32'd0);
    step(1'b1, 1'b0, 1'b1, 8'h44);
    check("lat_q4", 32'(q4), 32'h11);
    check("lat_v4", 32'(v4), 32'd1);
    check("lat_c4", 32'(c4), 32'd4);
    check("lat_q1", 32'(q1), 32'h44);

    // stall with live input that must be ignored
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h99);
      check("stall_q4", 32'(q4), 32'h11);
      check("stall_c4", 32'(c4), 32'd4);
      check("stall_q1", 32'(q1), 32'h44);
    end
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("resume_q4", 32'(q4), 32'h22);
    check("resume_c4", 32'(c4), 32'd3);
    check("resume_q1", 32'(q1), 32'(RV));
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("resume_q4b", 32'(q4), 32'h33);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("resume_q4c", 32'(q4), 32'h44);
    check("resume_c4c", 32'(c4), 32'd1);

    // gating: invalid FF words
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'hFF);
      check("gate_q1", 32'(q1), 32'(RV));
    end
    check("gate_q4", 32'(q4), 32'(RV));
    check("gate_v4", 32'(v4), 32'd0);
    check("gate_c4", 32'(c4), 32'd0);
    check("nogate_qg", 32'(qg), 32'hFF);
    check("nogate_vg", 32'(vg), 32'd0);

    // flush priority over enable
    step(1'b1, 1'b0, 1'b1, 8'h01);
    step(1'b1, 1'b0, 1'b1, 8'h02);
    step(1'b1, 1'b0, 1'b1, 8'h03);
    step(1'b1, 1'b0, 1'b1, 8'h04);
    check("full_c4", 32'(c4), 32'd4);
    check("full_q4", 32'(q4), 32'h01);
    step(1'b1, 1'b0, 1'b1, 8'h05);
    check("full_slide_q4", 32'(q4), 32'h02);
    check("full_slide_c4", 32'(c4), 32'd4);
    step(1'b1, 1'b1, 1'b1, 8'h77);
    check("flush_q4", 32'(q4), 32'(RV));
    check("flush_v4", 32'(v4), 32'd0);
    check("flush_c4", 32'(c4), 32'd0);
    check("flush_q1", 32'(q1), 32'(RV));
    check("flush_qg", 32'(qg), 32'(RV));
    en = 1'b1; flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00);
      check("noflush77_q4", 32'(q4 == 8'h77), 32'd0);
    end
    check("postflush_qg", 32'(qg), 32'h00);

    // mid-stream async reset
    step(1'b1, 1'b0, 1'b1, 8'h55);
    step(1'b1, 1'b0, 1'b1, 8'h66);
    check("pre_rst_c4", 32'(c4), 32'd2);
    #2 res = 1'b1;
    #1;
    check("mid_rst_q4", 32'(q4), 32'(RV));
    check("mid_rst_c4", 32'(c4), 32'd0);
    check("mid_rst_q1", 32'(q1), 32'(RV));
    check("mid_rst_v1", 32'(v1), 32'd0);
    clear_q();
    res = 1'b0;
    step(1'b1, 1'b0, 1'b1, 8'h88);
    check("post_rst_q1", 32'(q1), 32'h88);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("post_rst_v4_early", 32'(v4), 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("post_rst_q4", 32'(q4), 32'h88);
    check("post_rst_v4", 32'(v4), 32'd1);

    step(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    check("drain4", 32'(exp4.size()), 32'd0);
    check("drain1", 32'(exp1.size()), 32'd0);
    check("draing", 32'(expg.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
